dmem_responder: RTL

//  Memory-side responder for the multicycle core's data-memory requests (ld/sd path).

---
 rtl/dmem_pkg.sv | 6 +
 rtl/dmem_array.sv | 21 ++
 rtl/dmem_responder.sv | 84 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
endpackage

// File: rtl/dmem_array.sv
// Doubleword storage: synchronous write, registered read, contents never reset.
module dmem_array #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              WE,
    input  logic              RE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge CLK) begin
        if (WE)
            mem[ADDR] <= WDATA;
        if (RE)
            RDATA <= mem[ADDR];
    end
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: fixed-latency access, one-cycle response strobe.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_VALID,
    input  logic              REQ_RW,
    input  logic [63:0]       REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              REQ_READY,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR
);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t       state, state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] idx_q;
    logic              rw_q;
    logic              err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] arr_rdata;

    logic accept, req_err, access, mem_we, mem_re;

    assign accept  = REQ_VALID && (state == IDLE);
    assign req_err = (REQ_ADDR[2:0] != 3'b0) || (REQ_ADDR[63:ADDR_W+3] != '0);
    assign access  = (state == BUSY) && (cnt == 4'd0);
    // A reset landing on the access cycle must drop the pending write.
    assign mem_we  = access && (rw_q == MEM_WRITE) && !RESET;
    assign mem_re  = access && (rw_q == MEM_READ);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            rw_q    <= MEM_READ;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx_q   <= REQ_ADDR[ADDR_W+2:3];
                rw_q    <= REQ_RW;
                err_q   <= req_err;
                wdata_q <= REQ_WDATA;
                cnt     <= CNT_INIT;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = req_err ? RESP : BUSY;
            BUSY: if (cnt == 4'd0) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    dmem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
        .CLK   (CLK),
        .WE    (mem_we),
        .RE    (mem_re),
        .ADDR  (idx_q),
        .WDATA (wdata_q),
        .RDATA (arr_rdata)
    );

    assign REQ_READY = (state == IDLE);
    assign RSP_VALID = (state == RESP);
    assign RSP_ERR   = (state == RESP) && err_q;
    assign RSP_RDATA = (state == RESP && !err_q && rw_q == MEM_READ) ? arr_rdata : '0;
endmodule
